// File: rtl/pull_fanout_source.sv
// Fan-out FIFO: one valid/ready push port feeding several req/ack pull consumers.
// A word is retired only once every consumer has taken it.
module pull_fanout_source #(
    parameter int unsigned           data_width    = 32,
    parameter int unsigned           depth         = 4,
    parameter int unsigned           output_size   = 2,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [data_width-1:0]              in_data,
    input  logic [output_size-1:0]             req,
    output logic [output_size-1:0]             ack,
    output logic [data_width*output_size-1:0]  dout,
    output logic [31:0]                        count
);

    localparam int unsigned aw = $clog2(depth);
    typedef logic [aw:0] ptr_t;
    localparam ptr_t depth_ptr = ptr_t'(depth);
    localparam ptr_t ptr_one   = ptr_t'(1);

    logic [data_width-1:0]  mem [depth];
    ptr_t                   wp;
    ptr_t                   rp [output_size];
    logic                   full;
    logic                   push;
    logic [output_size-1:0] pull;

    // The slowest consumer decides fullness.
    always_comb begin
        full = 1'b0;
        for (int i = 0; i < output_size; i++) begin
            if (ptr_t'(wp - rp[i]) == depth_ptr) full = 1'b1;
        end
    end

    assign in_ready = rst & ~full;
    assign push     = in_valid & in_ready;

    // Availability uses pre-edge pointers, so a word pushed this edge is not served until the next.
    always_comb begin
        pull = '0;
        for (int i = 0; i < output_size; i++) begin
            pull[i] = req[i] & ~ack[i] & (rp[i] != wp);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            wp    <= wp + ptr_one;
            count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[aw-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack <= '0;
            for (int i = 0; i < output_size; i++) begin
                rp[i]                            <= '0;
                dout[i*data_width +: data_width] <= initial_value;
            end
        end else begin
            for (int i = 0; i < output_size; i++) begin
                ack[i] <= pull[i];
                if (pull[i]) begin
                    dout[i*data_width +: data_width] <= mem[rp[i][aw-1:0]];
                    rp[i]                            <= rp[i] + ptr_one;
                end
            end
        end
    end

endmodule

// File: tb/tb_pull_fanout_source.sv
// Directed bench for pull_fanout_source (depth 4, two consumers) with a per-consumer
// expected-word queue and a cycle model of ack, dout, count and in_ready.
module tb_pull_fanout_source;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    req = '0;
    logic [1:0]    ack;
    logic [2*DW-1:0] dout;
    logic [31:0]   count;

    pull_fanout_source #(
        .data_width   (DW),
        .depth        (DEPTH),
        .output_size  (2),
        .initial_value('0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .req     (req),
        .ack     (ack),
        .dout    (dout),
        .count   (count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] cnt_model = '0;
    logic [1:0]  prev_exp_ack = '0;
    logic [31:0] dout_model0 = '0;
    logic [31:0] dout_model1 = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return rst && (q0.size() < DEPTH) && (q1.size() < DEPTH);
    endfunction

    function automatic bit model_empty();
        return (q0.size() == 0) && (q1.size() == 0);
    endfunction

    // One clock: predict from pre-edge state, advance, then compare #1 after the edge.
    task automatic step(output bit accepted);
        bit exp_ack0, exp_ack1;
        accepted = in_valid && model_ready();
        exp_ack0 = req[0] && !prev_exp_ack[0] && (q0.size() > 0);
        exp_ack1 = req[1] && !prev_exp_ack[1] && (q1.size() > 0);
        if (exp_ack0) dout_model0 = q0.pop_front();
        if (exp_ack1) dout_model1 = q1.pop_front();
        if (accepted) begin
            q0.push_back(in_data);
            q1.push_back(in_data);
            cnt_model++;
        end
        @(posedge clk);
        #1;
        check("ack0", 64'(ack[0]), 64'(exp_ack0));
        check("ack1", 64'(ack[1]), 64'(exp_ack1));
        check("dout0", 64'(dout[31:0]), 64'(dout_model0));
        check("dout1", 64'(dout[63:32]), 64'(dout_model1));
        check("count", 64'(count), 64'(cnt_model));
        check("in_ready", 64'(in_ready), 64'(model_ready()));
        prev_exp_ack = {exp_ack1, exp_ack0};
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        req      = 2'b11;
        for (int c = 0; c < 40 && !model_empty(); c++) step(acc);
        check("drain_done", 64'(model_empty()), 64'd1);
        req = 2'b00;
        step(acc);
    endtask

    initial begin
        bit acc;
        int sent;

        // Reset state
        #2;
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Back-to-back push of 0..3 with req held on both consumers
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            step(acc);
        end
        drain();

        // Backpressure: consumer 1 idle, offer 6 words
        req  = 2'b00;
        sent = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(sent);
            step(acc);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(sent), 64'd4);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        req = 2'b01;
        for (int k = 0; k < 10; k++) step(acc);
        check("bp_still_full", 64'(in_ready), 64'd0);
        req = 2'b10;
        step(acc);
        check("bp_ready_after_ack1", 64'(in_ready), 64'd1);
        drain();

        // Reset mid-stream with ack[0] high and words buffered
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h200 + 32'(k);
            step(acc);
        end
        in_valid = 1'b0;
        req = 2'b01;
        step(acc);
        check("pre_rst_ack0", 64'(ack[0]), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_ack", 64'(ack), 64'd0);
        check("midrst_dout", 64'(dout), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        q0.delete();
        q1.delete();
        cnt_model    = '0;
        prev_exp_ack = '0;
        dout_model0  = '0;
        dout_model1  = '0;
        req = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_after_midrst", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'h55;
        step(acc);
        in_valid = 1'b0;
        req = 2'b01;
        step(acc);
        check("first_after_rst", 64'(dout[31:0]), 64'h55);
        drain();

        // Unequal rates: consumer 0 always requests, consumer 1 one cycle in five
        sent = 0;
        for (int c = 0; c < 400 && !(sent >= 20 && model_empty()); c++) begin
            in_valid = (sent < 20);
            in_data  = 32'(sent);
            req      = {1'(c % 5 == 0), 1'b1};
            step(acc);
            if (acc) sent++;
        end
        check("unequal_sent", 64'(sent), 64'd20);
        check("unequal_empty", 64'(model_empty()), 64'd1);
        drain();

        // Random toggling across pointer wraps
        sent = 0;
        for (int c = 0; c < 300 && !(sent >= 3*DEPTH+1 && model_empty()); c++) begin
            in_valid = (sent < 3*DEPTH+1) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = 32'h300 + 32'(sent);
            req      = 2'($urandom_range(0, 3));
            step(acc);
            if (acc) sent++;
        end
        check("wrap_sent", 64'(sent), 64'(3*DEPTH+1));
        check("wrap_empty", 64'(model_empty()), 64'd1);
        drain();

        // Request withdrawal on an empty FIFO
        req = 2'b01;
        step(acc);
        step(acc);
        req      = 2'b00;
        in_valid = 1'b1;
        in_data  = 32'd7;
        step(acc);
        in_valid = 1'b0;
        step(acc);
        step(acc);
        req = 2'b01;
        step(acc);
        check("withdraw_ack0", 64'(ack[0]), 64'd1);
        check("withdraw_dout0", 64'(dout[31:0]), 64'd7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pull_fanout_source.md
# pull_fanout_source

Buffered responder for the req/ack pull handshake used between async dataflow operators. It accepts words on a valid/ready push port and stores them in a small FIFO. It serves those words to `output_size` independent pull consumers; each consumer raises `req` and receives a one-cycle `ack` with data. A word is retired only after every consumer has taken it, which gives fan-out of one stream to several graph nodes that run at different rates.

## Interface
- `data_width`, 32, width of every data word
- `depth`, 4, FIFO entries; power of two, ≥2
- `output_size`, 2, number of pull consumers, ≥1
- `initial_value`, 0, reset value of every `dout` slice

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low (low = in reset)
- `in_valid`  in  1  push word present
- `in_ready`  out  1  block can accept a word this cycle
- `in_data`  in  data_width  push word
- `req`  in  output_size  per-consumer pull request, bit i = consumer i
- `ack`  out  output_size  per-consumer one-cycle acknowledge pulse
- `dout`  out  data_width*output_size  per-consumer data; slice i = bits [data_width*(i+1)-1 : data_width*i]
- `count`  out  32  number of words accepted on the push port; wraps modulo 2^32

## Operation
- Storage: `mem[depth]`. Write pointer `wp` and per-consumer read pointers `rp[i]`, each log2(depth)+1 bits wide; all pointer arithmetic is modulo 2*depth.
- Consumer i has data available when `rp[i] != wp`.
- The FIFO is full when `wp - rp[i] == depth` for any i, so the slowest consumer gates the input.
- `in_ready` = not full. It is combinational from the pointers and is forced to 0 while `rst` is low.
- Push: on `in_valid & in_ready`, write `mem[wp[low bits]] <= in_data`, then `wp <= wp+1` and `count <= count+1`.
- Pull for each consumer i, evaluated independently every cycle: if `req[i] & ~ack[i]` and data is available for i, then on that edge:
  - `ack[i] <= 1`
  - `dout` slice i `<= mem[rp[i][low bits]]`
  - `rp[i] <= rp[i]+1`
- Otherwise `ack[i] <= 0`.
- `dout` slice i holds its value until consumer i's next ack.
- `ack[i]` never stays high two consecutive cycles. A consumer holding `req` high continuously is served at most every other cycle.
- `req` may drop at any time without an ack. No state changes for that consumer and no data is lost.
- Words are never dropped or duplicated. Each consumer receives every accepted word exactly once, in push order.

## Timing
- Reset (rst low, asynchronous):
  - `wp`, all `rp` = 0; `count` = 0; `ack` = 0
  - every `dout` slice = `initial_value`
  - `in_ready` = 0
- After rst rises: `in_ready` = 1 from the first cycle.
- Latency: a word written at edge k can be acked at edge k+1 at the earliest. There is no same-edge bypass.
- Simultaneous push and pull in one cycle are legal:
  - A pull that frees the last full slot does not raise `in_ready` until the following cycle, because ready is computed from the pre-edge pointers.
  - A push into an empty FIFO does not satisfy a `req` on the same edge.
- Wrap-around: pointers wrap at 2*depth; full and empty detection stays correct across wraps.
- Reset mid-operation: all buffered words are discarded, any in-flight `ack` is cleared immediately, and `count` returns to 0.
- Throughput: with `req` held high and the FIFO never empty, each consumer receives one word every 2 cycles. The push port sustains 1 word/cycle until full.

## Test plan
- Reset: drive rst low mid-stream, with `ack[0]` high and 3 words buffered -> `ack`=0, `dout` slices=`initial_value`, `count`=0 and `in_ready`=0 immediately. After release, `in_ready`=1 and the next word pushed (0x55) is the first delivered.
- Single consumer, in order (output_size=1): push 0,1,2,3 back-to-back with `req` held high -> `ack` pulses on alternate cycles, `dout` = 0,1,2,3, first ack exactly one edge after the first push.
- Full / backpressure (depth=4, output_size=2): consumer 1 holds `req`=0; push 6 words with `in_valid` high -> 4 accepted and `in_ready`=0. Consumer 0 drains all 4, and `in_ready` stays 0 until consumer 1 takes one word; `in_ready` rises the cycle after that ack.
- Unequal rates: consumer 0 holds `req` high, consumer 1 requests 1 cycle in 5; push 20 incrementing words -> both receive 0..19 exactly once in order, `count`=20, no word lost while full.
- Wrap-around: push and pull 3*depth+1 words with randomly toggling `req` and `in_valid` -> a scoreboard sees no mismatches, and `in_ready` and available status are correct at every pointer wrap.
- Req withdrawal: raise `req[0]` with the FIFO empty, drop it after 2 cycles, then push 7 -> no ack while `req` is low. The next `req[0]` yields `ack[0]` with `dout` slice 0 = 7.
